// File: rtl/synapse.sv
// synapse: weighted-sum front end of one neuron, with an LMS
// weight update driven by the delta stream from the threshold unit.
module synapse #(
   parameter int N    = 2,
   parameter int RATE = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        train,
   input  logic        activation_valid,
   input  logic [7:0]  activation_data,
   output logic        activation_ready,
   output logic        argument_valid,
   output logic [15:0] argument_data,
   input  logic        argument_ready,
   input  logic        delta_valid,
   input  logic [15:0] delta_data,
   output logic        delta_ready
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      ACCUMULATE,
      ARGUMENT,
      DELTA,
      UPDATE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [IW-1:0]      r_idx;
   logic signed [31:0] r_acc;
   logic signed [15:0] r_w [N];
   logic [7:0]         r_x [N];
   logic signed [15:0] r_delta;

   logic               w_last;
   logic signed [24:0] w_prod;
   logic signed [24:0] w_dx;
   logic signed [24:0] w_inc;
   logic signed [25:0] w_upd;
   logic signed [31:0] w_sum;
   logic [15:0]        w_arg;
   logic [15:0]        w_wnew;

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         return 16'h7fff;
      else if (v < -32'sd32768)
         return 16'h8000;
      return v[15:0];
   endfunction

   assign w_last = (r_idx == LAST);
   // x is unsigned Q0.8, so it enters the signed multiply zero-extended
   assign w_prod = 25'(r_w[r_idx]) * 25'($signed({1'b0, activation_data}));
   assign w_dx   = 25'(r_delta) * 25'($signed({1'b0, r_x[r_idx]}));
   assign w_inc  = w_dx >>> (8 + RATE);
   assign w_upd  = 26'(r_w[r_idx]) + 26'(w_inc);
   assign w_sum  = r_acc >>> 8;
   assign w_arg  = sat16(w_sum);
   assign w_wnew = sat16(32'(w_upd));

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= ACCUMULATE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ACCUMULATE:
            if (activation_valid && w_last)
               w_next = ARGUMENT;
         ARGUMENT:
            if (argument_ready)
               w_next = train ? DELTA : ACCUMULATE;
         DELTA:
            if (delta_valid)
               w_next = UPDATE;
         UPDATE:
            if (w_last)
               w_next = ACCUMULATE;
         default:
            w_next = ACCUMULATE;
      endcase
   end

   always_comb begin
      activation_ready = 1'b0;
      argument_valid   = 1'b0;
      delta_ready      = 1'b0;
      argument_data    = 16'h0000;
      if (!reset) begin
         unique case (r_state)
            ACCUMULATE: activation_ready = 1'b1;
            ARGUMENT: begin
               argument_valid = 1'b1;
               argument_data  = w_arg;
            end
            DELTA:      delta_ready = 1'b1;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx   <= '0;
         r_acc   <= '0;
         r_delta <= '0;
         for (int k = 0; k < N; k++) begin
            r_w[k] <= '0;
            r_x[k] <= '0;
         end
      end else begin
         unique case (r_state)
            ACCUMULATE:
               if (activation_valid) begin
                  r_x[r_idx] <= activation_data;
                  r_acc      <= r_acc + 32'(w_prod);
                  r_idx      <= w_last ? '0 : r_idx + 1'b1;
               end
            ARGUMENT:
               if (argument_ready)
                  r_acc <= '0;
            DELTA:
               if (delta_valid)
                  r_delta <= delta_data;
            UPDATE: begin
               r_w[r_idx] <= w_wnew;
               r_idx      <= w_last ? '0 : r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_synapse.sv
// tb_synapse: table vectors, hand-written corner sequences and random
// passes checked against an arithmetic model of the neuron front end.
module tb_synapse;
   localparam int N    = 2;
   localparam int RATE = 0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        train = 1'b0;
   logic        activation_valid = 1'b0;
   logic [7:0]  activation_data = 8'h00;
   logic        activation_ready;
   logic        argument_valid;
   logic [15:0] argument_data;
   logic        argument_ready = 1'b0;
   logic        delta_valid = 1'b0;
   logic [15:0] delta_data = 16'h0000;
   logic        delta_ready;

   always #5 clock = ~clock;

   synapse #(.N(N), .RATE(RATE)) dut (
      .clock            (clock),
      .reset            (reset),
      .train            (train),
      .activation_valid (activation_valid),
      .activation_data  (activation_data),
      .activation_ready (activation_ready),
      .argument_valid   (argument_valid),
      .argument_data    (argument_data),
      .argument_ready   (argument_ready),
      .delta_valid      (delta_valid),
      .delta_data       (delta_data),
      .delta_ready      (delta_ready)
   );

   int checks = 0;
   int failures = 0;
   int mw [N];
   int mx [N];

   typedef struct packed {
      logic        rst;
      logic [7:0]  x0;
      logic [7:0]  x1;
      logic        trn;
      logic [15:0] dlt;
      logic [15:0] arg;
      logic [15:0] w0;
      logic [15:0] w1;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for handshake", nm);
   endtask

   function automatic int sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic logic [15:0] model_arg();
      longint s = 0;
      for (int i = 0; i < N; i++)
         s += longint'(mw[i]) * longint'(mx[i]);
      return 16'(sat16(s >>> 8));
   endfunction

   task automatic model_update(input logic [15:0] d);
      longint dl = longint'($signed(d));
      for (int i = 0; i < N; i++)
         mw[i] = sat16(longint'(mw[i]) + ((dl * mx[i]) >>> (8 + RATE)));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mw[i] = 0;
         mx[i] = 0;
      end
   endtask

   task automatic chk_w(input string nm);
      chk({nm, "_w0"}, dut.r_w[0], 16'(mw[0]));
      chk({nm, "_w1"}, dut.r_w[1], 16'(mw[1]));
   endtask

   task automatic send_act(input logic [7:0] v);
      int n = 0;
      activation_valid = 1'b1;
      activation_data  = v;
      while (!activation_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!activation_ready) tmo("act_hs");
      @(negedge clock);
      activation_valid = 1'b0;
   endtask

   task automatic recv_arg(input logic t, input int stall,
                           output logic [15:0] d);
      int n = 0;
      train = t;
      argument_ready = 1'b0;
      repeat (stall) @(negedge clock);
      argument_ready = 1'b1;
      while (!argument_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!argument_valid) tmo("arg_hs");
      d = argument_data;
      @(negedge clock);
      argument_ready = 1'b0;
      train = 1'($urandom_range(0, 1));
   endtask

   task automatic send_delta(input logic [15:0] d);
      int n = 0;
      delta_valid = 1'b1;
      delta_data  = d;
      while (!delta_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!delta_ready) tmo("delta_hs");
      @(negedge clock);
      delta_valid = 1'b0;
      model_update(d);
   endtask

   task automatic run_pass(input logic [7:0] a0, input logic [7:0] a1,
                           input logic t, input logic [15:0] d,
                           input int stall, output logic [15:0] arg);
      logic [15:0] exp;
      send_act(a0);
      send_act(a1);
      mx[0] = a0;
      mx[1] = a1;
      exp = model_arg();
      chk("arg_latency", argument_valid, 1'b1);
      recv_arg(t, stall, arg);
      chk("model_arg", arg, exp);
      if (t) begin
         chk("delta_ready_next", delta_ready, 1'b1);
         chk("act_ready_in_delta", activation_ready, 1'b0);
         send_delta(d);
         for (int k = 0; k < N; k++) begin
            chk("update_quiet",
                activation_ready | delta_ready | argument_valid, 1'b0);
            @(negedge clock);
         end
         chk("act_after_update", activation_ready, 1'b1);
      end else begin
         chk("act_ready_next", activation_ready, 1'b1);
         chk("no_delta_ready", delta_ready, 1'b0);
      end
      chk_w("model");
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      activation_valid = 1'b0;
      delta_valid = 1'b0;
      argument_ready = 1'b0;
      @(negedge clock);
      chk("rst_act_ready", activation_ready, 1'b0);
      chk("rst_arg_valid", argument_valid, 1'b0);
      chk("rst_delta_ready", delta_ready, 1'b0);
      chk("rst_arg_data", argument_data, 16'h0000);
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      chk("act_ready_after_rst", activation_ready, 1'b1);
   endtask

   initial begin
      logic [15:0] got;
      logic [15:0] exp;
      logic [15:0] d;

      tbl[0] = '{1'b1, 8'hff, 8'hff, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[1] = '{1'b0, 8'hff, 8'hff, 1'b1, 16'h0100, 16'h0000, 16'h00ff, 16'h00ff};
      tbl[2] = '{1'b0, 8'hff, 8'h00, 1'b0, 16'h0000, 16'h00fe, 16'h00ff, 16'h00ff};
      tbl[3] = '{1'b0, 8'hff, 8'hff, 1'b1, 16'hffff, 16'h01fc, 16'h00fe, 16'h00fe};
      tbl[4] = '{1'b1, 8'hff, 8'hff, 1'b1, 16'h7fff, 16'h0000, 16'h7f7f, 16'h7f7f};
      tbl[5] = '{1'b0, 8'hff, 8'hff, 1'b1, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff};
      tbl[6] = '{1'b0, 8'hff, 8'hff, 1'b0, 16'h0000, 16'h7fff, 16'h7fff, 16'h7fff};
      tbl[7] = '{1'b0, 8'hff, 8'hff, 1'b1, 16'h8000, 16'h7fff, 16'h007f, 16'h007f};
      tbl[8] = '{1'b0, 8'h80, 8'h40, 1'b0, 16'h0000, 16'h005f, 16'h007f, 16'h007f};

      model_reset();
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].rst) do_reset();
         run_pass(tbl[i].x0, tbl[i].x1, tbl[i].trn, tbl[i].dlt, 0, got);
         chk("tbl_arg", got, tbl[i].arg);
         chk("tbl_w0", dut.r_w[0], tbl[i].w0);
         chk("tbl_w1", dut.r_w[1], tbl[i].w1);
      end

      // back-pressure with weights 007f; offered activations must be ignored
      send_act(8'hff);
      send_act(8'hff);
      mx[0] = 255;
      mx[1] = 255;
      exp = model_arg();
      chk("bp_exp_const", exp, 16'h00fd);
      activation_valid = 1'b1;
      activation_data  = 8'h11;
      repeat (5) begin
         chk("bp_valid", argument_valid, 1'b1);
         chk("bp_data", argument_data, exp);
         chk("bp_act_ready", activation_ready, 1'b0);
         @(negedge clock);
      end
      activation_valid = 1'b0;
      recv_arg(1'b0, 0, got);
      chk("bp_arg", got, exp);
      run_pass(8'h80, 8'h40, 1'b0, 16'h0, 0, got);
      chk("bp_after_arg", got, 16'h005f);

      // reset coinciding with the last activation handshake
      send_act(8'hff);
      activation_valid = 1'b1;
      activation_data  = 8'hff;
      reset = 1'b1;
      @(negedge clock);
      chk("rw_act_ready", activation_ready, 1'b0);
      chk("rw_arg_data", argument_data, 16'h0000);
      activation_valid = 1'b0;
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      chk("rw_act_ready_after", activation_ready, 1'b1);
      chk("rw_no_arg", argument_valid, 1'b0);
      chk_w("rw");
      run_pass(8'hff, 8'hff, 1'b0, 16'h0, 0, got);
      chk("rw_arg", got, 16'h0000);

      // reset while argument is stalled
      run_pass(8'hff, 8'hff, 1'b1, 16'h0100, 0, got);
      send_act(8'hff);
      send_act(8'hff);
      mx[0] = 255;
      mx[1] = 255;
      chk("stall_arg_data", argument_data, model_arg());
      do_reset();
      chk_w("arg_rst");

      // reset while waiting in DELTA
      run_pass(8'hff, 8'hff, 1'b1, 16'h0100, 0, got);
      send_act(8'hff);
      send_act(8'hff);
      recv_arg(1'b1, 2, got);
      repeat (3) begin
         chk("delta_stall", delta_ready, 1'b1);
         @(negedge clock);
      end
      do_reset();
      chk_w("delta_rst");
      run_pass(8'hff, 8'hff, 1'b0, 16'h0, 0, got);
      chk("delta_rst_arg", got, 16'h0000);

      // random passes against the model
      do_reset();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0)
            d = ($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000;
         else
            d = 16'($urandom_range(0, 2047)) - 16'd1024;
         repeat ($urandom_range(0, 2)) @(negedge clock);
         run_pass(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  d, $urandom_range(0, 3), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
